ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter WIDTHAD, default 12: RAM address width.
REQ-003 SHALL have parameter WIDTH, default 28: RAM data width.
REQ-004 SHALL have port clock0 input 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid input NREQ: per-requester access request.
REQ-007 SHALL have port req_ready output NREQ: one-hot grant, this cycle.
REQ-008 SHALL have port req_we input NREQ: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr input NREQ*WIDTHAD: packed addresses, requester i at bits [i*WIDTHAD +: WIDTHAD].
REQ-010 SHALL have port req_data input NREQ*WIDTH: packed write data, same packing as req_addr.
REQ-011 SHALL have port rsp_valid output NREQ: one-hot read-data-valid.
REQ-012 SHALL have port rsp_data output WIDTH: read data; equals ram_q.
REQ-013 SHALL have port ram_address output WIDTHAD: drives the RAM port address.
REQ-014 SHALL have port ram_wren output 1: drives the RAM port write enable.
REQ-015 SHALL have port ram_data output WIDTH: drives the RAM port write data.
REQ-016 SHALL have port ram_q input WIDTH: RAM port read data, valid one cycle after the address.
REQ-017 SHALL have port init_done output 1: high once the clear sweep completes.

Function
REQ-018 SHALL implement states CLEAR and SERVE; reset enters CLEAR with the sweep counter at 0.
REQ-019 In CLEAR: ram_address = counter, ram_wren = 1, ram_data = 0, req_ready = 0; counter increments each cycle.
REQ-020 Counter reaching 2^WIDTHAD-1 SHALL write that address, then enter SERVE next cycle with init_done = 1; no address skipped, no wrap.
REQ-021 In SERVE: at most one req_ready bit per cycle, only for a requester with req_valid = 1; no request means ram_wren = 0.
REQ-022 Granted requester i: ram_address, ram_wren = req_we[i], ram_data are driven combinationally from slot i in the same cycle; grant = transfer.
REQ-023 Granted read in cycle t: rsp_valid[i] = 1 in cycle t+1 with rsp_data = ram_q; writes generate no response.
REQ-024 Read granted the cycle after a write to the same address SHALL return the new data.
REQ-025 Back-to-back grants SHALL sustain one access per cycle; a requester may hold req_valid across cycles.
REQ-026 req_valid deasserted without grant SHALL be legal; no state retained for it.

Reset
REQ-027 Reset SHALL force: req_ready = 0, rsp_valid = 0, ram_wren = 0, init_done = 0, arbitration pointer = 0, counter = 0.
REQ-028 Reset asserted mid-sweep or mid-SERVE SHALL restart the sweep at address 0 and discard any pending response.

Configuration
REQ-029 With RAM_ARB_RR_EN defined: round-robin; after granting i, priority order is i+1, ..., NREQ-1, 0, ..., i.
REQ-030 Without RAM_ARB_RR_EN: fixed priority, lowest index wins; pointer register absent.

Structure
REQ-031 Package ram_arb_pkg SHALL hold the state enum (CLEAR, SERVE) and default parameter constants.
REQ-032 Grant selection SHALL live in sub-module rr_arbiter (req, pointer in; one-hot grant out), also used for fixed priority with pointer tied to 0.

Verification
REQ-033 Reset, NREQ=4, WIDTHAD=4 -> 16 clear writes to addresses 0..15 with data 0; init_done = 1 on cycle 17; no req_ready before then.
REQ-034 Requester 2 writes 0x5A to address 3, then reads address 3 next cycle -> rsp_valid = 0b0100 one cycle after the read grant, rsp_data = 0x5A.
REQ-035 All four hold req_valid continuously (RR build) -> grants 0,1,2,3,0,... one per cycle, with no gaps.
REQ-036 Same stimulus, fixed-priority build -> requester 0 granted every cycle; others starved.
REQ-037 Reset asserted at sweep address 7 -> sweep restarts at 0; init_done stays 0 until the full sweep completes.
REQ-038 Read granted in cycle t, reset in cycle t+1 -> rsp_valid = 0 in t+1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default parameter values for the RAM port arbiter.
package ram_arb_pkg;

  // CLEAR zero-fills the whole RAM after reset; SERVE arbitrates requesters.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTHAD = 12;
  localparam int DEF_WIDTH   = 28;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant selection starting at i_ptr and wrapping round.
// With i_ptr tied to zero it reduces to lowest-index-wins priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_gnt;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    w_rot     = N'({i_req, i_req} >> i_ptr);
    w_rot_gnt = w_rot & (~w_rot + 1'b1);
    o_grant   = N'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> N);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multiplexes NREQ requesters onto one single-port synchronous RAM.
// After reset every address is written with zero (CLEAR), then one
// access per cycle is granted (SERVE). Read data returns one cycle
// after the grant on rsp_data with a one-hot rsp_valid.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority with the lowest index winning.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTHAD = DEF_WIDTHAD,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                    clock0,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*WIDTHAD-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [WIDTHAD-1:0]      ram_address,
  output logic                    ram_wren,
  output logic [WIDTH-1:0]        ram_data,
  input  logic [WIDTH-1:0]        ram_q,
  output logic                    init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTHAD-1:0] LAST_ADDR = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTHAD-1:0]  r_cnt;
  logic [NREQ-1:0]     r_rsp_vld;
  logic [PW-1:0]       w_ptr;
  logic [NREQ-1:0]     w_arb_grant;
  logic [NREQ-1:0]     w_grant;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_arb_grant)
  );

  // Grants only exist in SERVE and are suppressed while reset is held
  assign w_grant = (r_state == SERVE && !reset) ? w_arb_grant : '0;

`ifdef RAM_ARB_RR_EN
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  // Next pointer: the requester just after the one granted this cycle
  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  // Priority pointer register
  always_ff @(posedge clock0) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nxt;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // State register
  always_ff @(posedge clock0) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave CLEAR only after the last address has been written
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_cnt == LAST_ADDR) w_state_nxt = SERVE;
  end

  // Sweep counter; stops at the last address so it never wraps
  always_ff @(posedge clock0) begin
    if (reset)                                     r_cnt <= '0;
    else if (r_state == CLEAR && r_cnt != LAST_ADDR) r_cnt <= r_cnt + 1'b1;
  end

  // RAM port and grant outputs; everything quiet while reset is high
  always_comb begin
    req_ready   = '0;
    ram_address = '0;
    ram_wren    = 1'b0;
    ram_data    = '0;
    if (!reset) begin
      case (r_state)
        CLEAR: begin
          ram_address = r_cnt;
          ram_wren    = 1'b1;
        end
        SERVE: begin
          req_ready = w_grant;
          for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
              ram_address = req_addr[i*WIDTHAD +: WIDTHAD];
              ram_wren    = req_we[i];
              ram_data    = req_data[i*WIDTH +: WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Remember which requester's read lands on ram_q next cycle
  always_ff @(posedge clock0) begin
    if (reset) r_rsp_vld <= '0;
    else       r_rsp_vld <= w_grant & ~req_we;
  end

  assign rsp_valid = reset ? '0 : r_rsp_vld;
  assign rsp_data  = ram_q;
  assign init_done = (r_state == SERVE) && !reset;

endmodule
